// File: rtl/add_reduce.sv
// rtl/add_reduce.sv - multi-cycle operand reduction using up to N_ADD adders per step
//
// Purpose:
//   Loads N_IN operands on r_enable, then folds them pairwise, at most N_ADD
//   additions per cycle, until one value is left. That value becomes
//   result, and w_enable pulses for one cycle.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   r_enable   - start strobe; loads init_data and (re)starts a job
//   init_data  - N_IN operands, operand i at [i*IN_W +: IN_W]
//   busy       - high from load until the DONE cycle inclusive
//   w_enable   - one-cycle pulse, result valid
//   result     - job sum, held until the next w_enable
//   sat_flag   - (ADD_REDUCE_SAT_EN only) some addition in the job clamped
//
// Configuration:
//   ADD_REDUCE_SAT_EN - when defined, additions clamp to all-ones on
//                       carry-out and sat_flag is present; otherwise
//                       additions wrap modulo 2^OUT_W.

module add_reduce #(
    parameter int N_IN  = 7,
    parameter int IN_W  = 10,
    parameter int OUT_W = 13,
    parameter int N_ADD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r_enable,
    input  logic [N_IN*IN_W-1:0] init_data,
    output logic                 busy,
    output logic                 w_enable,
    output logic [OUT_W-1:0]     result
`ifdef ADD_REDUCE_SAT_EN
    ,
    output logic                 sat_flag
`endif
);

    localparam int K_W   = $clog2(N_IN + 1);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    // At most this many adders can ever be busy, whatever k is.
    localparam int PAIRS = (N_ADD < N_IN / 2) ? N_ADD : N_IN / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [K_W-1:0]   r_k;
    logic [OUT_W-1:0] r_slot     [N_IN];
    logic [OUT_W-1:0] w_slot_nxt [N_IN];
    logic [OUT_W-1:0] r_result;
    int               w_k;
    int               w_p;
`ifdef ADD_REDUCE_SAT_EN
    logic             r_sat;
    logic             w_step_sat;
    logic [OUT_W:0]   w_sum;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // A start strobe wins in every state, so it discards any job in flight.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (r_enable) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   w_state_nxt = (r_k <= K_W'(1)) ? S_DONE : S_RUN;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (r_state != S_IDLE);
        w_enable = (r_state == S_DONE);
    end

    assign result = r_result;
`ifdef ADD_REDUCE_SAT_EN
    assign sat_flag = r_sat;
`endif

    // ---------------- one reduction step ----------------
    // Live values occupy slots 0..k-1. The first 2p slots are summed pairwise
    // into slots 0..p-1. The leftover k-2p values slide down to sit right
    // behind the sums. Slots at and above the new k are don't-care.
    always_comb begin
        w_k = 32'(r_k);
        w_p = (w_k / 2 < N_ADD) ? (w_k / 2) : N_ADD;
`ifdef ADD_REDUCE_SAT_EN
        w_step_sat = 1'b0;
        w_sum      = '0;
`endif
        for (int d = 0; d < N_IN; d++) begin
            w_slot_nxt[IDX_W'(d)] = r_slot[IDX_W'(d)];
        end
        for (int i = 0; i < PAIRS; i++) begin
            if (i < w_p) begin
`ifdef ADD_REDUCE_SAT_EN
                w_sum = {1'b0, r_slot[IDX_W'(2 * i)]} + {1'b0, r_slot[IDX_W'(2 * i + 1)]};
                if (w_sum[OUT_W]) begin
                    w_slot_nxt[IDX_W'(i)] = '1;
                    w_step_sat            = 1'b1;
                end else begin
                    w_slot_nxt[IDX_W'(i)] = w_sum[OUT_W-1:0];
                end
`else
                w_slot_nxt[IDX_W'(i)] = r_slot[IDX_W'(2 * i)] + r_slot[IDX_W'(2 * i + 1)];
`endif
            end
        end
        for (int d = 0; d < N_IN; d++) begin
            if (d >= w_p && d < w_k - w_p) begin
                w_slot_nxt[IDX_W'(d)] = r_slot[IDX_W'(d + w_p)];
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < N_IN; d++) begin
                r_slot[IDX_W'(d)] <= '0;
            end
            r_k      <= '0;
            r_result <= '0;
`ifdef ADD_REDUCE_SAT_EN
            r_sat    <= 1'b0;
`endif
        end else if (r_enable) begin
            for (int d = 0; d < N_IN; d++) begin
                r_slot[IDX_W'(d)] <= OUT_W'(init_data[d*IN_W +: IN_W]);
            end
            r_k <= K_W'(N_IN);
`ifdef ADD_REDUCE_SAT_EN
            r_sat <= 1'b0;
`endif
        end else if (r_state == S_RUN) begin
            if (r_k > K_W'(1)) begin
                for (int d = 0; d < N_IN; d++) begin
                    r_slot[IDX_W'(d)] <= w_slot_nxt[IDX_W'(d)];
                end
                r_k <= r_k - K_W'(w_p);
`ifdef ADD_REDUCE_SAT_EN
                r_sat <= r_sat | w_step_sat;
`endif
            end else begin
                r_result <= r_slot[0];
            end
        end
    end

endmodule

// File: tb/tb_add_reduce.sv
// tb/tb_add_reduce.sv - scoreboard bench for add_reduce over four parameter sets

module tb_add_reduce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en0, en1, en2, en3;
    logic [69:0] d0, d1, d3;
    logic [9:0]  d2;
    logic        busy0, busy1, busy2, busy3;
    logic        we0, we1, we2, we3;
    logic [12:0] res0, res1, res2;
    logic [9:0]  res3;
    logic        sat0, sat1, sat2, sat3;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint val;
        int     due;
        bit     sat;
    } exp_t;

    exp_t q [4][$];

    add_reduce #(.N_IN(7), .IN_W(10), .OUT_W(13), .N_ADD(2)) u0 (
        .clk(clk), .rst(rst), .r_enable(en0), .init_data(d0),
        .busy(busy0), .w_enable(we0), .result(res0)
`ifdef ADD_REDUCE_SAT_EN
        , .sat_flag(sat0)
`endif
    );
    add_reduce #(.N_IN(7), .IN_W(10), .OUT_W(13), .N_ADD(3)) u1 (
        .clk(clk), .rst(rst), .r_enable(en1), .init_data(d1),
        .busy(busy1), .w_enable(we1), .result(res1)
`ifdef ADD_REDUCE_SAT_EN
        , .sat_flag(sat1)
`endif
    );
    add_reduce #(.N_IN(1), .IN_W(10), .OUT_W(13), .N_ADD(2)) u2 (
        .clk(clk), .rst(rst), .r_enable(en2), .init_data(d2),
        .busy(busy2), .w_enable(we2), .result(res2)
`ifdef ADD_REDUCE_SAT_EN
        , .sat_flag(sat2)
`endif
    );
    add_reduce #(.N_IN(7), .IN_W(10), .OUT_W(10), .N_ADD(2)) u3 (
        .clk(clk), .rst(rst), .r_enable(en3), .init_data(d3),
        .busy(busy3), .w_enable(we3), .result(res3)
`ifdef ADD_REDUCE_SAT_EN
        , .sat_flag(sat3)
`endif
    );

`ifndef ADD_REDUCE_SAT_EN
    initial begin
        sat0 = 1'b0; sat1 = 1'b0; sat2 = 1'b0; sat3 = 1'b0;
    end
`endif

    function automatic int cfg_n(int inst);
        return (inst == 2) ? 1 : 7;
    endfunction
    function automatic int cfg_outw(int inst);
        return (inst == 3) ? 10 : 13;
    endfunction
    function automatic int cfg_nadd(int inst);
        return (inst == 1) ? 3 : 2;
    endfunction

    task automatic check(string name, longint got, longint req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Reference: the job result is just the arithmetic sum of the operands,
    // wrapped or clamped; the step count comes from shrinking k by min(N_ADD,k/2).
    function automatic exp_t model(int inst, logic [69:0] data, int load_edge);
        exp_t   e;
        longint sum = 0;
        longint max;
        int     k;
        int     s = 0;
        logic [69:0] dv = data;
        for (int i = 0; i < cfg_n(inst); i++) sum += longint'(dv[i*10 +: 10]);
        max = (longint'(1) << cfg_outw(inst)) - 1;
`ifdef ADD_REDUCE_SAT_EN
        e.val = (sum > max) ? max : sum;
        e.sat = (sum > max);
`else
        e.val = sum % (max + 1);
        e.sat = 1'b0;
`endif
        k = cfg_n(inst);
        while (k > 1) begin
            k -= (k / 2 < cfg_nadd(inst)) ? k / 2 : cfg_nadd(inst);
            s++;
        end
        e.due = load_edge + s + 1;
        return e;
    endfunction

    function automatic logic [69:0] rnd_ops(bit high);
        logic [69:0] v;
        for (int i = 0; i < 7; i++)
            v[i*10 +: 10] = high ? 10'($urandom_range(700, 1023)) : 10'($urandom_range(0, 1023));
        return v;
    endfunction

    function automatic logic [69:0] fill(int a, int step);
        logic [69:0] v;
        for (int i = 0; i < 7; i++) v[i*10 +: 10] = 10'(a + i * step);
        return v;
    endfunction

    task automatic issue(int inst, logic [69:0] data);
        int le;
        @(posedge clk);
        #1;
        le = cyc + 1;
        case (inst)
            0: begin en0 = 1'b1; d0 = data; end
            1: begin en1 = 1'b1; d1 = data; end
            2: begin en2 = 1'b1; d2 = data[9:0]; end
            default: begin en3 = 1'b1; d3 = data; end
        endcase
        // A job whose result edge has not yet passed is discarded by the restart.
        if (q[inst].size() > 0 && q[inst][$].due >= le) void'(q[inst].pop_back());
        q[inst].push_back(model(inst, data, le));
        @(posedge clk);
        #1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
        d0 = rnd_ops(1'b0); d1 = rnd_ops(1'b0); d3 = rnd_ops(1'b0);
        d2 = 10'($urandom_range(0, 1023));
    endtask

    function automatic int pending();
        return q[0].size() + q[1].size() + q[2].size() + q[3].size();
    endfunction

    task automatic wait_idle();
        for (int t = 0; t < 60 && pending() != 0; t++) @(negedge clk);
        check("drain_pending", pending(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic mon(int inst, logic we, longint res, logic sat);
        exp_t e;
        if (we) begin
            if (q[inst].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse u%0d: w_enable=1 required 0 (cycle %0d)", inst, cyc);
            end else begin
                e = q[inst].pop_front();
                check($sformatf("result_u%0d", inst), res, e.val);
                check($sformatf("latency_u%0d", inst), cyc, e.due);
`ifdef ADD_REDUCE_SAT_EN
                check($sformatf("sat_flag_u%0d", inst), longint'(sat), longint'(e.sat));
`else
                if (sat) $display("note: sat input unexpectedly set");
`endif
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, we0, longint'(res0), sat0);
        mon(1, we1, longint'(res1), sat1);
        mon(2, we2, longint'(res2), sat2);
        mon(3, we3, longint'(res3), sat3);
    end

    initial begin
        int busy_cnt;
        rst = 1'b1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy0, 0);
        check("reset_w_enable", we0, 0);
        check("reset_result", res0, 0);
        rst = 1'b0;

        // Operands 1..7 on defaults: sum 28, busy six cycles.
        issue(0, fill(1, 1));
        busy_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (busy0) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, 6);
        wait_idle();

        // Three adders, single operand, all-max operands on a narrow result.
        issue(1, fill(1, 1));
        wait_idle();
        issue(2, 70'd5);
        wait_idle();
        issue(3, fill(1023, 0));
        wait_idle();

        // Restart two edges after the first job: only the second one reports.
        issue(0, fill(1, 1));
        issue(0, fill(2, 0));
        wait_idle();

        // Reset in the middle of a job.
        issue(0, fill(1, 1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy0, 0);
        check("midrst_w_enable", we0, 0);
        check("midrst_result", res0, 0);
        for (int i = 0; i < 4; i++) q[i].delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, fill(1, 1));
        wait_idle();

        // Random jobs with random gaps, which include restarts.
        for (int n = 0; n < 80; n++) begin
            int inst;
            inst = $urandom_range(0, 3);
            issue(inst, rnd_ops((inst == 3) && ($urandom_range(0, 1) == 1)));
            repeat ($urandom_range(0, 7)) @(posedge clk);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
